// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and the
// {pc, instr} record carried through the prefetch queue.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int PC_W        = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the ROM, redirect, decode-handshake and fault signals of fetch_ctrl.
// master is the fetch side, slave is the environment (ROM, execute, decode).
interface fetch_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32
);

  logic [ADDRESS_WIDTH-1:0] rom_pc;
  logic [31:0]              rom_instr;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [ADDRESS_WIDTH-1:0] out_pc;
  logic                     fault;
  logic [ADDRESS_WIDTH-1:0] fault_pc;

  modport master (
    output rom_pc, out_valid, out_instr, out_pc, fault, fault_pc,
    input  rom_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_pc, out_valid, out_instr, out_pc, fault, fault_pc,
    output rom_instr, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry circular FIFO of fetch entries; flush beats push, and a push
// into a full queue is accepted only when the head pops in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;
  fetch_entry_t     slot [DEPTH];

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = slot[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      fetch_entry_t entry_reg;

      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= push_entry;
        end
      end

      assign slot[gi] = entry_reg;
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures {pc, instr} from the
// combinational ROM into a prefetch queue, and handles redirects and faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       ROM_BYTES     = 4096,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       DEPTH         = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PC = ADDRESS_WIDTH'(ROM_BYTES - INSTR_BYTES);

  fetch_state_t             state_reg;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_reg;
  logic                     fault_reg;
  logic [ADDRESS_WIDTH-1:0] fault_pc_reg;

  logic         q_push;
  logic         q_pop;
  logic         q_flush;
  logic         q_full;
  logic         q_empty;
  logic         out_valid_int;
  logic         in_run;
  fetch_entry_t q_head;
  fetch_entry_t q_entry;

  function automatic logic pc_legal(input logic [ADDRESS_WIDTH-1:0] pc);
    return (pc[1:0] == 2'b00) && (pc <= LAST_PC);
  endfunction

  assign in_run        = (state_reg == RUN);
  assign out_valid_int = !q_empty && (state_reg != IDLE);
  assign q_pop         = out_valid_int && bus.out_ready;
  assign q_flush       = in_run && bus.redirect_valid;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign q_push        = in_run && !bus.redirect_valid && pc_legal(fetch_pc_reg)
                         && (!q_full || q_pop);

  assign q_entry.pc    = PC_W'(fetch_pc_reg);
  assign q_entry.instr = bus.rom_instr;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (q_flush),
    .push_entry(q_entry),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      fault_reg    <= 1'b0;
      fault_pc_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= RUN;
        RUN: begin
          if (bus.redirect_valid) begin
            if (pc_legal(bus.redirect_pc)) begin
              fetch_pc_reg <= bus.redirect_pc;
            end else begin
              state_reg    <= FAULT;
              fault_reg    <= 1'b1;
              fault_pc_reg <= bus.redirect_pc;
            end
          end else if (!pc_legal(fetch_pc_reg)) begin
            state_reg    <= FAULT;
            fault_reg    <= 1'b1;
            fault_pc_reg <= fetch_pc_reg;
          end else if (q_push) begin
            fetch_pc_reg <= fetch_pc_reg + ADDRESS_WIDTH'(INSTR_BYTES);
          end
        end
        FAULT: state_reg <= FAULT;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Head fields are forced to zero while nothing is presented.
  assign bus.rom_pc    = fetch_pc_reg;
  assign bus.out_valid = out_valid_int;
  assign bus.out_pc    = out_valid_int ? ADDRESS_WIDTH'(q_head.pc) : '0;
  assign bus.out_instr = out_valid_int ? q_head.instr : 32'h0;
  assign bus.fault     = fault_reg;
  assign bus.fault_pc  = fault_pc_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised scoreboard bench for fetch_ctrl: a queue-based reference model predicts
// each decode transfer; a negedge monitor pops and compares them.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int ROMB  = 4096;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDRESS_WIDTH(AW)) bus ();

  fetch_ctrl #(
    .ADDRESS_WIDTH(AW),
    .ROM_BYTES    (ROMB),
    .RESET_PC     (32'h0),
    .DEPTH        (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] rom_words [ROMB/4];
  assign bus.rom_instr = (bus.rom_pc < 32'(ROMB)) ? rom_words[bus.rom_pc[11:2]] : 32'hdead_beef;

  ent_t        mq[$];
  ent_t        exp_q[$];
  ent_t        mon_e;
  bit          m_started;
  bit          m_faulted;
  logic [31:0] m_pc;
  logic [31:0] m_fault_pc;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] p);
    return (p[1:0] == 2'b00) && (p <= 32'(ROMB - 4));
  endfunction

  // Reference model: what the next rising edge does given the inputs now on the bus.
  task automatic model_edge();
    if (!rst_n) begin
      mq.delete();
      m_started  = 0;
      m_faulted  = 0;
      m_pc       = 32'h0;
      m_fault_pc = 32'h0;
      return;
    end
    if (m_started && mq.size() > 0 && bus.out_ready) exp_q.push_back(mq.pop_front());
    if (!m_started) begin
      m_started = 1;
    end else if (!m_faulted) begin
      if (bus.redirect_valid) begin
        mq.delete();
        if (legal(bus.redirect_pc)) m_pc = bus.redirect_pc;
        else begin
          m_faulted  = 1;
          m_fault_pc = bus.redirect_pc;
        end
      end else if (!legal(m_pc)) begin
        m_faulted  = 1;
        m_fault_pc = m_pc;
      end else if (mq.size() < DEPTH) begin
        mq.push_back('{m_pc, rom_words[m_pc[11:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_status();
    bit v;
    v = m_started && (mq.size() > 0);
    chk("out_valid", 32'(bus.out_valid), 32'(v));
    if (v) begin
      chk("head_pc", bus.out_pc, mq[0].pc);
      chk("head_instr", bus.out_instr, mq[0].instr);
    end
    chk("rom_pc", bus.rom_pc, m_pc);
    chk("fault", 32'(bus.fault), 32'(m_faulted));
    chk("fault_pc", bus.fault_pc, m_fault_pc);
  endtask

  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst_n              = rst;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    model_edge();
    @(posedge clk);
    #1;
    check_status();
  endtask

  // Monitor: every handshake the DUT presents must match the next predicted transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL xfer_unexpected: got pc %h want no transfer", bus.out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer_pc", bus.out_pc, mon_e.pc);
          chk("xfer_instr", bus.out_instr, mon_e.instr);
          $display("[TB] xfer pc=%h instr=%h", bus.out_pc, bus.out_instr);
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < ROMB / 4; i++) rom_words[i] = $urandom;
    rom_words[0] = 32'h0000_0013;
    rom_words[1] = 32'h0010_0093;
    rom_words[2] = 32'h0020_0113;

    // Reset and first-fetch latency
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("lat_edge1_valid", 32'(bus.out_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("lat_edge2_valid", 32'(bus.out_valid), 32'h1);
    chk("lat_edge2_pc", bus.out_pc, 32'h0);
    chk("lat_edge2_instr", bus.out_instr, 32'h0000_0013);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Backpressure: queue fills, everything holds
    step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (12) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_rom_pc", bus.rom_pc, 32'h8);
    chk("hold_out_pc", bus.out_pc, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with a full queue while the head transfers
    step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_target_pc", bus.out_pc, 32'h40);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect faults; later redirects ignored; reset clears
    step(1'b1, 1'b1, 32'h42, 1'b1);
    chk("mis_fault", 32'(bus.fault), 32'h1);
    chk("mis_fault_pc", bus.fault_pc, 32'h42);
    step(1'b1, 1'b1, 32'h10, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("clr_fault", 32'(bus.fault), 32'h0);
    chk("clr_rom_pc", bus.rom_pc, 32'h0);

    // Run off the end of the ROM
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'hff0, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("end_fault_pc", bus.fault_pc, 32'h1000);
    chk("end_out_valid", 32'(bus.out_valid), 32'h0);

    // Reset mid-stream with one entry queued
    step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_rom_pc", bus.rom_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mid_rst_restart", 32'(bus.out_valid), 32'h1);

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 9))
        8:       rpc = 32'($urandom_range(0, ROMB - 1)) | 32'h1;
        9:       rpc = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        7:       rpc = 32'hff8;
        default: rpc = 32'($urandom_range(0, ROMB / 4 - 1)) * 32'd4;
      endcase
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 11) == 0), rpc,
           ($urandom_range(0, 9) < 7));
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
